// File: rtl/avalon_pio_master.sv
// Avalon-MM initiator for fixed-latency PIO slaves: single read/write commands
// over valid/ready, read responses over valid/ready, optional address-0 change polling.
module avalon_pio_master #(
  parameter int ADDR_W        = 2,
  parameter int DATA_W        = 32,
  parameter int READ_LATENCY  = 1,
  parameter int POLL_INTERVAL = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              poll_en,
  output logic              change_valid,
  output logic [DATA_W-1:0] change_data,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [ADDR_W-1:0] avm_address,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata
);

  localparam int TMR_W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_INTERVAL - 1);
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;
  typedef enum logic {TAG_CMD, TAG_POLL} tag_t;

  state_t            state_reg, state_next;
  tag_t              tag_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [CNT_W-1:0]  rd_cnt_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic              poll_pending_reg;
  logic              poll_seen_reg;
  logic              poll_abort_reg;
  logic              change_valid_reg;
  logic [DATA_W-1:0] change_data_reg;

  logic cmd_fire;
  logic poll_start;
  logic rd_last;
  logic timer_expire;

  assign cmd_fire     = (state_reg == IDLE) && cmd_valid;
  assign poll_start   = (state_reg == IDLE) && !cmd_valid && poll_pending_reg;
  assign rd_last      = (state_reg == RD) && (rd_cnt_reg == RD_LAST);
  assign timer_expire = (timer_reg == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_fire) begin
          state_next = cmd_write ? WR : RD;
        end else if (poll_start) begin
          state_next = RD;
        end
      end
      WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        state_next     = IDLE;
      end
      RD: begin
        avm_chipselect = 1'b1;
        if (rd_last) begin
          state_next = (tag_reg == TAG_POLL) ? IDLE : RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transfer latch and read capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_reg    <= TAG_CMD;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      rd_cnt_reg <= '0;
    end else begin
      if (cmd_fire) begin
        tag_reg   <= TAG_CMD;
        addr_reg  <= cmd_addr;
        wdata_reg <= cmd_wdata;
      end else if (poll_start) begin
        tag_reg  <= TAG_POLL;
        addr_reg <= '0;
      end
      if (state_reg == RD) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end else begin
        rd_cnt_reg <= '0;
      end
      if (rd_last && (tag_reg == TAG_CMD)) begin
        rdata_reg <= avm_readdata;
      end
    end
  end

  // Poll scheduling and change detection; disabling polling overrides everything
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer_reg        <= TMR_RELOAD;
      poll_pending_reg <= 1'b0;
      poll_seen_reg    <= 1'b0;
      poll_abort_reg   <= 1'b0;
      change_valid_reg <= 1'b0;
      change_data_reg  <= '0;
    end else begin
      change_valid_reg <= 1'b0;
      timer_reg        <= timer_expire ? TMR_RELOAD : timer_reg - 1'b1;
      poll_pending_reg <= timer_expire || (poll_pending_reg && !poll_start);

      if (!poll_en) begin
        poll_abort_reg <= 1'b1;
      end else if (poll_start) begin
        poll_abort_reg <= 1'b0;
      end

      if (rd_last && (tag_reg == TAG_POLL) && poll_en && !poll_abort_reg) begin
        if (!poll_seen_reg) begin
          change_data_reg <= avm_readdata;
          poll_seen_reg   <= 1'b1;
        end else if (avm_readdata != change_data_reg) begin
          change_data_reg  <= avm_readdata;
          change_valid_reg <= 1'b1;
        end
      end

      if (!poll_en) begin
        timer_reg        <= TMR_RELOAD;
        poll_pending_reg <= 1'b0;
        poll_seen_reg    <= 1'b0;
      end
    end
  end

  assign avm_address   = addr_reg;
  assign avm_writedata = wdata_reg;
  assign rsp_rdata     = rdata_reg;
  assign change_valid  = change_valid_reg;
  assign change_data   = change_data_reg;

endmodule

// File: tb/tb_avalon_pio_master.sv
// Directed bench for avalon_pio_master with a registered one-cycle-latency PIO slave model.
module tb_avalon_pio_master;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        poll_en, change_valid;
  logic [31:0] change_data;
  logic        avm_chipselect, avm_write_n;
  logic [1:0]  avm_address;
  logic [31:0] avm_writedata, avm_readdata;

  logic [31:0] slave_in0;
  logic [31:0] regs [0:3];

  int checks = 0;
  int failures = 0;
  int rsp_cycles = 0;
  int pulse_cnt = 0;
  int poll_rd_cnt = 0;
  logic cs_prev = 1'b0;

  always #5 clk = ~clk;

  avalon_pio_master #(
    .ADDR_W(2), .DATA_W(32), .READ_LATENCY(1), .POLL_INTERVAL(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .poll_en(poll_en), .change_valid(change_valid), .change_data(change_data),
    .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata)
  );

  // Slave: address 0 is an input port, 1..3 are read/write registers
  always @(posedge clk) begin
    if (!reset_n) begin
      regs[0] <= 32'h0;
      regs[1] <= 32'h1111_0001;
      regs[2] <= 32'h2222_0002;
      regs[3] <= 32'h3333_0003;
      avm_readdata <= 32'h0;
    end else begin
      if (avm_chipselect && !avm_write_n && avm_address != 2'd0) regs[avm_address] <= avm_writedata;
      if (avm_chipselect && avm_write_n) avm_readdata <= (avm_address == 2'd0) ? slave_in0 : regs[avm_address];
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) rsp_cycles++;
    if (change_valid) pulse_cnt++;
    if (avm_chipselect && !cs_prev && avm_write_n && avm_address == 2'd0) poll_rd_cnt++;
    cs_prev = avm_chipselect;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) step();
    checks++; if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin failures++; $display("FAIL reset_avalon got=%h exp=%h", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b0, 1'b1, 2'd0, 32'h0}); end
    checks++; if ({rsp_valid, rsp_rdata, change_valid, change_data} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {rsp_valid, rsp_rdata, change_valid, change_data}); end
    reset_n = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write;
    int r0;
    r0 = rsp_cycles;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_wdata = 32'h0000_00A5;
    step();
    cmd_valid = 1'b0;
    checks++; if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, cmd_ready} !== {1'b1, 1'b0, 2'd0, 32'hA5, 1'b0}) begin failures++; $display("FAIL write_t1 got=%h exp=%h", {avm_chipselect, avm_write_n, avm_address, avm_writedata, cmd_ready}, {1'b1, 1'b0, 2'd0, 32'hA5, 1'b0}); end
    step();
    checks++; if ({cmd_ready, avm_chipselect} !== 2'b10) begin failures++; $display("FAIL write_t2 got=%b exp=10", {cmd_ready, avm_chipselect}); end
    repeat (4) step();
    checks++; if (rsp_cycles !== r0) begin failures++; $display("FAIL write_no_rsp got=%0d exp=%0d", rsp_cycles, r0); end
  endtask

  task automatic test_read;
    slave_in0 = 32'h0000_003C;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd0;
    step();
    cmd_valid = 1'b0;
    checks++; if ({avm_chipselect, avm_write_n, avm_address, rsp_valid} !== {1'b1, 1'b1, 2'd0, 1'b0}) begin failures++; $display("FAIL read_t1 got=%b exp=1100", {avm_chipselect, avm_write_n, avm_address, rsp_valid}); end
    step();
    checks++; if ({avm_chipselect, rsp_valid} !== 2'b10) begin failures++; $display("FAIL read_t2 got=%b exp=10", {avm_chipselect, rsp_valid}); end
    step();
    checks++; if ({rsp_valid, rsp_rdata, avm_chipselect} !== {1'b1, 32'h3C, 1'b0}) begin failures++; $display("FAIL read_t3 got=%h exp=%h", {rsp_valid, rsp_rdata, avm_chipselect}, {1'b1, 32'h3C, 1'b0}); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({rsp_valid, rsp_rdata, cmd_ready} !== {1'b1, 32'h3C, 1'b0}) begin failures++; $display("FAIL read_hold%0d got=%h exp=%h", i, {rsp_valid, rsp_rdata, cmd_ready}, {1'b1, 32'h3C, 1'b0}); end
    end
    step();
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h3C}) begin failures++; $display("FAIL read_hs_cycle got=%h exp=%h", {rsp_valid, rsp_rdata}, {1'b1, 32'h3C}); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL read_after_hs got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_back_to_back;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd1; cmd_wdata = 32'hDEAD_BEEF;
    step();
    cmd_write = 1'b0; cmd_wdata = 32'h0;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", cmd_ready); end
    step();
    step();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    checks++; if ({avm_chipselect, avm_write_n, avm_address} !== 4'b1101) begin failures++; $display("FAIL b2b_rd_addr got=%b exp=1101", {avm_chipselect, avm_write_n, avm_address}); end
    step();
    step();
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", {rsp_valid, rsp_rdata}, {1'b1, 32'hDEAD_BEEF}); end
    step();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL b2b_rsp_1cyc got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_poll_basic;
    int n, p0, r;
    p0 = pulse_cnt;
    slave_in0 = 32'h11;
    poll_en = 1'b1;
    n = 0;
    while (n < 40 && !(avm_chipselect && avm_address == 2'd0)) begin step(); n++; end
    checks++; if (n !== 17) begin failures++; $display("FAIL poll_first_cycle got=%0d exp=17", n); end
    step(); step();
    checks++; if ({change_valid, change_data} !== {1'b0, 32'h11}) begin failures++; $display("FAIL poll_first_val got=%h exp=%h", {change_valid, change_data}, {1'b0, 32'h11}); end
    slave_in0 = 32'h22;
    n = 0;
    while (n < 40 && !change_valid) begin step(); n++; end
    checks++; if (n !== 16) begin failures++; $display("FAIL poll_change_cycle got=%0d exp=16", n); end
    checks++; if (change_data !== 32'h22) begin failures++; $display("FAIL poll_change_data got=%h exp=22", change_data); end
    step();
    checks++; if ({change_valid, change_data} !== {1'b0, 32'h22}) begin failures++; $display("FAIL poll_pulse_width got=%h exp=%h", {change_valid, change_data}, {1'b0, 32'h22}); end
    r = poll_rd_cnt;
    repeat (40) step();
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL poll_no_repeat got=%0d exp=1", pulse_cnt - p0); end
    checks++; if (poll_rd_cnt - r !== 2) begin failures++; $display("FAIL poll_period got=%0d exp=2", poll_rd_cnt - r); end
    poll_en = 1'b0;
    step();
  endtask

  task automatic test_priority;
    int r, p0;
    p0 = pulse_cnt;
    poll_en = 1'b1;
    repeat (16) step();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL prio_idle got=%b exp=1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd1; rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    r = poll_rd_cnt;
    checks++; if ({avm_chipselect, avm_address} !== 3'b101) begin failures++; $display("FAIL prio_cmd_first got=%b exp=101", {avm_chipselect, avm_address}); end
    step(); step();
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin failures++; $display("FAIL prio_rsp got=%h exp=%h", {rsp_valid, rsp_rdata}, {1'b1, 32'hDEAD_BEEF}); end
    repeat (30) step();
    checks++; if ({rsp_valid, poll_rd_cnt - r} !== {1'b1, 32'd0}) begin failures++; $display("FAIL prio_stall got=%h exp=%h", {rsp_valid, poll_rd_cnt - r}, {1'b1, 32'd0}); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, avm_chipselect} !== 2'b00) begin failures++; $display("FAIL prio_rsp_done got=%b exp=00", {rsp_valid, avm_chipselect}); end
    step();
    checks++; if ({avm_chipselect, avm_write_n, avm_address} !== 4'b1100) begin failures++; $display("FAIL prio_poll_next got=%b exp=1100", {avm_chipselect, avm_write_n, avm_address}); end
    repeat (4) step();
    checks++; if (poll_rd_cnt - r !== 1) begin failures++; $display("FAIL prio_single_poll got=%0d exp=1", poll_rd_cnt - r); end
    checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL prio_no_pulse got=%0d exp=%0d", pulse_cnt, p0); end
    poll_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid;
    int r, p0;
    p0 = pulse_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2;
    step();
    cmd_valid = 1'b0;
    checks++; if ({avm_chipselect, avm_address} !== 3'b110) begin failures++; $display("FAIL rst_rd_addr got=%b exp=110", {avm_chipselect, avm_address}); end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++; if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, rsp_valid, rsp_rdata, change_valid, change_data} !== {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0}) begin failures++; $display("FAIL rst_in_rd got=%h exp=%h", {avm_chipselect, avm_write_n, avm_address, avm_writedata, rsp_valid, rsp_rdata, change_valid, change_data}, {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0}); end
    r = rsp_cycles;
    repeat (4) step();
    checks++; if (rsp_cycles !== r) begin failures++; $display("FAIL rst_rd_no_rsp got=%0d exp=%0d", rsp_cycles, r); end
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 2'd3;
    step();
    cmd_valid = 1'b0;
    step(); step();
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h3333_0003}) begin failures++; $display("FAIL rst_rsp_pre got=%h exp=%h", {rsp_valid, rsp_rdata}, {1'b1, 32'h3333_0003}); end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++; if ({rsp_valid, rsp_rdata, avm_chipselect, cmd_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin failures++; $display("FAIL rst_in_rsp got=%h exp=%h", {rsp_valid, rsp_rdata, avm_chipselect, cmd_ready}, {1'b0, 32'h0, 1'b0, 1'b1}); end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 2'd1;
    step();
    cmd_valid = 1'b0;
    step(); step();
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h1111_0001}) begin failures++; $display("FAIL rst_recover got=%h exp=%h", {rsp_valid, rsp_rdata}, {1'b1, 32'h1111_0001}); end
    step();
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, pulse_cnt - p0} !== {1'b0, 32'd0}) begin failures++; $display("FAIL rst_recover_done got=%h exp=0", {rsp_valid, pulse_cnt - p0}); end
  endtask

  task automatic test_poll_disable;
    int n, p0;
    slave_in0 = 32'h77;
    poll_en = 1'b1;
    n = 0;
    while (n < 40 && change_data !== 32'h77) begin step(); n++; end
    checks++; if (change_data !== 32'h77) begin failures++; $display("FAIL pdis_first got=%h exp=77", change_data); end
    p0 = pulse_cnt;
    slave_in0 = 32'h99;
    n = 0;
    while (n < 40 && !(avm_chipselect && avm_write_n && avm_address == 2'd0)) begin step(); n++; end
    checks++; if (avm_chipselect !== 1'b1) begin failures++; $display("FAIL pdis_poll_seen got=%b exp=1", avm_chipselect); end
    poll_en = 1'b0;
    repeat (4) step();
    checks++; if ({change_data, avm_chipselect} !== {32'h77, 1'b0}) begin failures++; $display("FAIL pdis_dropped got=%h exp=%h", {change_data, avm_chipselect}, {32'h77, 1'b0}); end
    checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL pdis_no_pulse got=%0d exp=%0d", pulse_cnt, p0); end
    poll_en = 1'b1;
    n = 0;
    while (n < 40 && change_data !== 32'h99) begin step(); n++; end
    checks++; if (change_data !== 32'h99) begin failures++; $display("FAIL pdis_reenable got=%h exp=99", change_data); end
    step(); step();
    checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL pdis_reenable_pulse got=%0d exp=%0d", pulse_cnt, p0); end
    poll_en = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 2'd0;
    cmd_wdata = 32'h0; rsp_ready = 1'b0; poll_en = 1'b0; slave_in0 = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_poll_basic();
    test_priority();
    test_reset_mid();
    test_poll_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
